// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port SRAM between instruction fetch and the
//             memory stage; fixed priority (MEM over IF), multi-cycle access
//             sequencer and pipeline freeze generation.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDRESS_LEN = 32,
    parameter int DATA_LEN    = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   if_req_i,
    input  logic [ADDRESS_LEN-1:0] if_addr_i,
    output logic [DATA_LEN-1:0]    if_data_o,
    output logic                   if_ready_o,

    input  logic                   mem_r_en_i,
    input  logic                   mem_w_en_i,
    input  logic [ADDRESS_LEN-1:0] mem_addr_i,
    input  logic [DATA_LEN-1:0]    mem_wdata_i,
    output logic [DATA_LEN-1:0]    mem_rdata_o,
    output logic                   mem_ready_o,

    output logic                   freeze_o,

    output logic                   sram_en_o,
    output logic                   sram_we_o,
    output logic [ADDRESS_LEN-1:0] sram_addr_o,
    output logic [DATA_LEN-1:0]    sram_wdata_o,
    input  logic [DATA_LEN-1:0]    sram_rdata_i
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic       c_OWN_IF    = 1'b0;
    localparam logic       c_OWN_MEM   = 1'b1;

    // Counter value on the last SRAM cycle of an access; read data is valid then.
    localparam logic [3:0] c_LAST_CNT  = 4'(WAIT_CYCLES - 1);

    logic [1:0]             state_q,     state_d;
    logic [3:0]             cnt_q,       cnt_d;
    logic                   owner_q,     owner_d;
    logic                   we_q,        we_d;
    logic [ADDRESS_LEN-1:0] addr_q,      addr_d;
    logic [DATA_LEN-1:0]    wdata_q,     wdata_d;
    logic [DATA_LEN-1:0]    if_data_q,   if_data_d;
    logic [DATA_LEN-1:0]    mem_rdata_q, mem_rdata_d;

    logic                   mem_req;

    assign mem_req = mem_r_en_i | mem_w_en_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            c_ST_IDLE: begin
                // Both enables high is a write: mem_w_en alone sets the flag.
                if (mem_req) begin
                    owner_d = c_OWN_MEM;
                    we_d    = mem_w_en_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    cnt_d   = 4'd0;
                    state_d = c_ST_ACCESS;
                end else if (if_req_i) begin
                    owner_d = c_OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                    cnt_d   = 4'd0;
                    state_d = c_ST_ACCESS;
                end
            end

            c_ST_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = c_ST_DONE;
                    if (owner_q == c_OWN_IF) begin
                        if_data_d = sram_rdata_i;
                    end else if (!we_q) begin
                        mem_rdata_d = sram_rdata_i;
                    end
                end
            end

            c_ST_DONE: begin
                cnt_d   = 4'd0;
                state_d = c_ST_IDLE;
            end

            default: begin
                cnt_d   = 4'd0;
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Async reset drops state immediately, so an access in flight is aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_ST_IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= c_OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign sram_en_o    = (state_q == c_ST_ACCESS);
    assign sram_we_o    = sram_en_o & we_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

    assign if_ready_o   = (state_q == c_ST_DONE) & (owner_q == c_OWN_IF);
    assign mem_ready_o  = (state_q == c_ST_DONE) & (owner_q == c_OWN_MEM);
    assign if_data_o    = if_data_q;
    assign mem_rdata_o  = mem_rdata_q;

    // Unregistered so the pipeline advances on the same edge mem_ready pulses.
    assign freeze_o     = mem_req & ~mem_ready_o;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, expected ready
// events queued at issue time and checked by independent monitors.
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT with default WAIT_CYCLES=4
    logic        if_req, if_ready, mem_r_en, mem_w_en, mem_ready, freeze;
    logic        sram_en, sram_we;
    logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    // DUT with WAIT_CYCLES=1
    logic        w1_if_req, w1_if_ready, w1_mem_r_en, w1_mem_w_en, w1_mem_ready, w1_freeze;
    logic        w1_sram_en, w1_sram_we;
    logic [31:0] w1_if_addr, w1_if_data, w1_mem_addr, w1_mem_wdata, w1_mem_rdata;
    logic [31:0] w1_sram_addr, w1_sram_wdata, w1_sram_rdata;

    logic [31:0] sram_mem [0:1023];
    assign sram_rdata    = sram_mem[sram_addr[11:2]];
    assign w1_sram_rdata = sram_mem[w1_sram_addr[11:2]];

    mem_port_arbiter #(.ADDRESS_LEN(32), .DATA_LEN(32), .WAIT_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
        .mem_r_en_i(mem_r_en), .mem_w_en_i(mem_w_en), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
        .freeze_o(freeze),
        .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    mem_port_arbiter #(.ADDRESS_LEN(32), .DATA_LEN(32), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(w1_if_req), .if_addr_i(w1_if_addr), .if_data_o(w1_if_data), .if_ready_o(w1_if_ready),
        .mem_r_en_i(w1_mem_r_en), .mem_w_en_i(w1_mem_w_en), .mem_addr_i(w1_mem_addr),
        .mem_wdata_i(w1_mem_wdata), .mem_rdata_o(w1_mem_rdata), .mem_ready_o(w1_mem_ready),
        .freeze_o(w1_freeze),
        .sram_en_o(w1_sram_en), .sram_we_o(w1_sram_we), .sram_addr_o(w1_sram_addr),
        .sram_wdata_o(w1_sram_wdata), .sram_rdata_i(w1_sram_rdata)
    );

    typedef struct {
        bit          is_mem;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];
    exp_t me, me1;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready monitor for the WAIT_CYCLES=4 instance
    always @(negedge clk) begin
        if (rst_n && (if_ready || mem_ready)) begin
            check("ready_exclusive", 32'(if_ready & mem_ready), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                me = sb.pop_front();
                check("ready_owner", 32'(mem_ready), 32'(me.is_mem));
                check("ready_cycle", 32'(cyc), 32'(me.cyc));
                check("ready_data", me.is_mem ? mem_rdata : if_data, me.data);
            end
        end
    end

    // Ready monitor for the WAIT_CYCLES=1 instance
    always @(negedge clk) begin
        if (rst_n && (w1_if_ready || w1_mem_ready)) begin
            if (sb1.size() == 0) begin
                check("w1_unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                me1 = sb1.pop_front();
                check("w1_ready_owner", 32'(w1_mem_ready), 32'(me1.is_mem));
                check("w1_ready_cycle", 32'(cyc), 32'(me1.cyc));
                check("w1_ready_data", me1.is_mem ? w1_mem_rdata : w1_if_data, me1.data);
            end
        end
    end

    // sram_en run length and write-enable containment
    int run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (sram_we) check("we_outside_access", 32'(sram_we & ~sram_en), 32'd0);
            if (sram_en) begin
                run++;
            end else if (run != 0) begin
                check("sram_en_run", 32'(run), 32'd4);
                run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit is_mem, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (is_mem ? mem_ready : if_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 10000", cyc);
        $fatal(1, "watchdog");
    end

    int          base;
    logic [31:0] exp_mem_rdata;

    initial begin
        for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
        sram_mem[32'h100 >> 2] = 32'hE3A0_1005;
        sram_mem[32'h108 >> 2] = 32'h0BAD_F00D;
        sram_mem[32'h400 >> 2] = 32'hDEAD_BEEF;
        sram_mem[32'h024 >> 2] = 32'h5555_5555;

        w1_if_req = 0; w1_if_addr = 0; w1_mem_r_en = 0; w1_mem_w_en = 0;
        w1_mem_addr = 0; w1_mem_wdata = 0;

        // Reset with both requesters active
        rst_n = 0; if_req = 1; if_addr = 32'h108;
        mem_r_en = 1; mem_w_en = 0; mem_addr = 32'h400; mem_wdata = 32'h0;
        repeat (3) tick();
        check("rst_if_data",    if_data,    32'h0);
        check("rst_mem_rdata",  mem_rdata,  32'h0);
        check("rst_if_ready",   32'(if_ready),  32'h0);
        check("rst_mem_ready",  32'(mem_ready), 32'h0);
        check("rst_sram_en",    32'(sram_en),   32'h0);
        check("rst_sram_we",    32'(sram_we),   32'h0);
        check("rst_sram_addr",  sram_addr,  32'h0);
        check("rst_sram_wdata", sram_wdata, 32'h0);
        check("rst_freeze",     32'(freeze),    32'h1);

        // Release: MEM wins, IF follows after re-arbitration
        rst_n = 1;
        base = cyc;
        sb.push_back('{1'b1, base + 5,  32'hDEAD_BEEF});
        sb.push_back('{1'b0, base + 11, 32'h0BAD_F00D});
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) check("sim_sram_addr", sram_addr, 32'h400);
            if (k == 4) check("sim_freeze_busy", 32'(freeze), 32'h1);
            if (k == 5) check("sim_freeze_done", 32'(freeze), 32'h0);
        end
        mem_r_en = 0;
        exp_mem_rdata = 32'hDEAD_BEEF;
        wait_ready(1'b0, "sim_if");
        if_req = 0;
        repeat (2) tick();
        check("sim_if_held",  if_data,   32'h0BAD_F00D);
        check("sim_mem_held", mem_rdata, exp_mem_rdata);

        // Single fetch
        if_req = 1; if_addr = 32'h100;
        base = cyc;
        sb.push_back('{1'b0, base + 5, 32'hE3A0_1005});
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("fetch_sram_en", 32'(sram_en), 32'(k <= 4));
            if (k == 1) check("fetch_sram_addr", sram_addr, 32'h100);
            if (k == 1) check("fetch_sram_we", 32'(sram_we), 32'h0);
        end
        if_req = 0;
        repeat (2) tick();
        check("fetch_held", if_data, 32'hE3A0_1005);

        // Write, with requester inputs changing after the grant
        mem_w_en = 1; mem_addr = 32'h20; mem_wdata = 32'h1234_5678;
        base = cyc;
        sb.push_back('{1'b1, base + 5, exp_mem_rdata});
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("wr_sram_we", 32'(sram_we), 32'(k <= 4));
            if (k == 1) begin
                check("wr_sram_addr",  sram_addr,  32'h20);
                check("wr_sram_wdata", sram_wdata, 32'h1234_5678);
                mem_addr = 32'h3FC; mem_wdata = 32'h0;
            end
            if (k == 3) begin
                check("wr_latched_addr",  sram_addr,  32'h20);
                check("wr_latched_wdata", sram_wdata, 32'h1234_5678);
            end
        end
        mem_w_en = 0;
        tick();

        // Read and write enables together behave as a write
        mem_r_en = 1; mem_w_en = 1; mem_addr = 32'h24; mem_wdata = 32'hCAFE_F00D;
        base = cyc;
        sb.push_back('{1'b1, base + 5, exp_mem_rdata});
        tick();
        check("rw_sram_we",    32'(sram_we), 32'h1);
        check("rw_sram_wdata", sram_wdata,   32'hCAFE_F00D);
        wait_ready(1'b1, "rw_mem");
        mem_r_en = 0; mem_w_en = 0;
        tick();
        check("rw_rdata_kept", mem_rdata, exp_mem_rdata);

        // Reset in the second ACCESS cycle of a fetch
        if_req = 1; if_addr = 32'h100;
        tick();
        tick();
        check("abort_pre_en", 32'(sram_en), 32'h1);
        rst_n = 0;
        #1;
        check("abort_sram_en",   32'(sram_en), 32'h0);
        check("abort_sram_we",   32'(sram_we), 32'h0);
        check("abort_if_data",   if_data,      32'h0);
        check("abort_mem_rdata", mem_rdata,    32'h0);
        tick();
        rst_n = 1;
        exp_mem_rdata = 32'h0;
        base = cyc;
        sb.push_back('{1'b0, base + 5, 32'hE3A0_1005});
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("restart_sram_en", 32'(sram_en), 32'(k <= 4));
        end
        if_req = 0;
        tick();

        // WAIT_CYCLES=1 instance
        w1_mem_r_en = 1; w1_mem_addr = 32'h400;
        base = cyc;
        sb1.push_back('{1'b1, base + 2, 32'hDEAD_BEEF});
        tick();
        check("w1_sram_en_c1", 32'(w1_sram_en), 32'h1);
        tick();
        check("w1_sram_en_c2", 32'(w1_sram_en), 32'h0);
        w1_mem_r_en = 0;

        repeat (3) tick();
        check("sb_drained",  32'(sb.size()),  32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port data/instruction SRAM between the instruction-fetch requester and the memory-stage requester (driven by the mem_r_en/mem_w_en/alu_res values leaving the execute stage). Fixed-priority arbitration (MEM over IF), a multi-cycle SRAM access sequencer with a programmable wait count, and per-requester ready pulses. Also produces the pipeline freeze that holds the IF, ID and EXE stage registers while a memory-stage access is outstanding.

## Interface
- ADDRESS_LEN, 32, byte address width for both requesters and the SRAM
- DATA_LEN, 32, data word width
- WAIT_CYCLES, 4, SRAM access cycles per transfer; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- if_req  input  1  fetch request, held high until if_ready
- if_addr  input  ADDRESS_LEN  fetch address
- if_data  output  DATA_LEN  fetched word, valid while if_ready=1, held afterwards
- if_ready  output  1  one-cycle completion pulse for fetch
- mem_r_en  input  1  memory-stage read request, held until mem_ready
- mem_w_en  input  1  memory-stage write request, held until mem_ready
- mem_addr  input  ADDRESS_LEN  memory-stage address
- mem_wdata  input  DATA_LEN  write data
- mem_rdata  output  DATA_LEN  read data, valid while mem_ready=1, held afterwards
- mem_ready  output  1  one-cycle completion pulse for memory-stage access
- freeze  output  1  combinational: (mem_r_en|mem_w_en) & ~mem_ready
- sram_en  output  1  SRAM access enable
- sram_we  output  1  SRAM write enable
- sram_addr  output  ADDRESS_LEN  SRAM address
- sram_wdata  output  DATA_LEN  SRAM write data
- sram_rdata  input  DATA_LEN  SRAM read data, valid on the last access cycle

## Operation
- States: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: if mem_r_en|mem_w_en -> grant MEM; else if if_req -> grant IF; else stay. On grant, latch owner, address, write data and write flag (mem_w_en); load counter with 0; go ACCESS.
- mem_r_en and mem_w_en both high: treated as write.
- ACCESS: sram_en=1, sram_addr/sram_wdata from latched values, sram_we=latched write flag. Counter increments each cycle; on the cycle counter == WAIT_CYCLES-1, capture sram_rdata into if_data (IF owner) or mem_rdata (MEM read); go DONE. MEM write does not alter mem_rdata.
- DONE: owner's ready=1 for exactly this cycle; sram_en=0; go IDLE unconditionally. Requests still high in the following IDLE cycle are new requests.
- Requests arriving during ACCESS/DONE wait; no preemption of an access in progress.
- Fixed priority: MEM always wins in IDLE. IF may be starved only while MEM requests are back-to-back (pipeline is frozen then anyway).
- Requester inputs may change after the grant edge; latched values are used for the whole access.
- freeze is not registered; it drops in the same cycle mem_ready pulses so the pipeline advances on that edge.

## Timing
- Reset (async, immediate): state IDLE, counter 0, all outputs 0 (if_data, mem_rdata, if_ready, mem_ready, sram_en, sram_we, sram_addr, sram_wdata); freeze follows its combinational equation.
- Reset asserted mid-ACCESS: SRAM access aborted immediately (sram_en/sram_we fall asynchronously), no ready pulse, captured data cleared.
- Latency: request seen in IDLE at cycle 0 -> ACCESS cycles 1..WAIT_CYCLES -> ready in cycle WAIT_CYCLES+1. Default: ready in cycle 5.
- Throughput: one access per WAIT_CYCLES+2 cycles; back-to-back requests re-arbitrate in IDLE.
- sram_en high for exactly WAIT_CYCLES consecutive cycles per access; sram_we never high outside ACCESS.
- if_ready and mem_ready are never high in the same cycle.

## Test plan
- Reset: rst=0 with all requests high -> all outputs 0, freeze=1 (from mem_*), sram_en=0; release -> MEM granted first.
- Single fetch: if_req=1, if_addr=0x100, SRAM returns 0xE3A01005 -> sram_en high cycles 1-4, if_ready pulse in cycle 5 with if_data=0xE3A01005, held after.
- Simultaneous: if_req and mem_r_en at cycle 0 (mem_addr=0x400, data 0xDEADBEEF) -> MEM served first, mem_ready cycle 5 with 0xDEADBEEF, freeze low cycle 5; IF served next, if_ready cycle 11.
- Write: mem_w_en=1, mem_addr=0x20, mem_wdata=0x12345678 -> sram_we=1 with those values cycles 1-4, mem_ready cycle 5, mem_rdata unchanged.
- Mid-access reset: assert rst=0 in cycle 2 of an IF access -> sram_en falls same cycle, no if_ready; after release a pending if_req restarts with full WAIT_CYCLES latency.
- WAIT_CYCLES=1 build: read at cycle 0 -> single sram_en cycle, ready in cycle 2.
